// File: rtl/uart_tx_if.sv
// Byte handshake between the APB-side transmit data path and the UART TX frame sequencer.
interface uart_tx_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;
  logic              par_en;
  logic              par_odd;

  modport master (
    output data_in, data_valid, par_en, par_odd,
    input  data_ready
  );

  modport slave (
    input  data_in, data_valid, par_en, par_odd,
    output data_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start, LSB-first data, optional parity, stop, paced by the divider tick.
// Also owns the divider rate select, which only moves while no frame is in flight.
module uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  uart_tx_if.slave   dp,
  input  logic [1:0] rate_req,
  output logic [1:0] rate_out,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [DATA_W-1:0] shift, shift_nxt;
  logic              par_en_q, par_en_nxt;
  logic              par_bit, par_bit_nxt;
  logic              tx_nxt;
  logic              busy_nxt;
  logic              ready_nxt;
  logic              done_nxt;
  logic [1:0]        rate_nxt;
  logic              accept_c;

  assign accept_c = (state == S_IDLE) && dp.data_valid;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      par_en_q      <= 1'b0;
      par_bit       <= 1'b0;
      tx            <= 1'b1;
      busy          <= 1'b0;
      dp.data_ready <= 1'b1;
      frame_done    <= 1'b0;
      rate_out      <= 2'b00;
    end else begin
      state         <= state_nxt;
      bit_cnt       <= bit_cnt_nxt;
      shift         <= shift_nxt;
      par_en_q      <= par_en_nxt;
      par_bit       <= par_bit_nxt;
      tx            <= tx_nxt;
      busy          <= busy_nxt;
      dp.data_ready <= ready_nxt;
      frame_done    <= done_nxt;
      rate_out      <= rate_nxt;
    end
  end

  // Next-state and next-output logic; every state holds until a tick arrives.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    par_en_nxt  = par_en_q;
    par_bit_nxt = par_bit;
    tx_nxt      = tx;
    done_nxt    = 1'b0;
    rate_nxt    = rate_out;

    case (state)
      S_IDLE: begin
        tx_nxt = 1'b1;
        if (rate_req != 2'b11) begin
          rate_nxt = rate_req;
        end
        if (accept_c) begin
          shift_nxt   = dp.data_in;
          par_en_nxt  = dp.par_en;
          par_bit_nxt = dp.par_odd ? ~^dp.data_in : ^dp.data_in;
          state_nxt   = S_SYNC;
        end
      end
      // Aligns the start bit to a tick; a tick coinciding with accept never reaches here.
      S_SYNC: begin
        if (tick) begin
          tx_nxt    = 1'b0;
          state_nxt = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          tx_nxt      = shift[0];
          shift_nxt   = shift >> 1;
          bit_cnt_nxt = '0;
          state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt == CNT_W'(DATA_W - 1)) begin
            if (par_en_q) begin
              tx_nxt    = par_bit;
              state_nxt = S_PARITY;
            end else begin
              tx_nxt    = 1'b1;
              state_nxt = S_STOP;
            end
          end else begin
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            tx_nxt      = shift[0];
            shift_nxt   = shift >> 1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_nxt    = 1'b1;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase

    busy_nxt  = (state_nxt != S_IDLE);
    ready_nxt = (state_nxt == S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed frame table, multi-cycle corner sequences and randomized traffic
// checked cycle by cycle against a queue-based line model.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] rate_req = 2'b00;
  logic [1:0] rate_out;
  logic       tx;
  logic       busy;
  logic       frame_done;

  uart_tx_if #(.DATA_W(8)) dp ();

  uart_tx_ctrl #(.DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .dp         (dp),
    .rate_req   (rate_req),
    .rate_out   (rate_out),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is just the queue of line bits still to be shifted out.
  bit         m_q[$];
  bit         m_active;
  bit         m_tx;
  bit         m_done;
  logic [1:0] m_rate;
  bit         acc_now;
  bit         fd_pre;
  bit         cap[$];
  int         n_pass;
  int         n_chk;

  typedef struct {
    logic [7:0]  data;
    bit          pe;
    bit          po;
    int          period;
    bit          tick_at_accept;
    int          nbits;
    logic [10:0] line;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_load(input logic [7:0] d, input bit pe, input bit po);
    bit pbit;
    m_q.delete();
    m_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) m_q.push_back(d[i]);
    pbit = (($countones(d) % 2) == 1) != po;
    if (pe) m_q.push_back(pbit);
    m_q.push_back(1'b1);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_tx     = 1'b1;
    m_done   = 1'b0;
    m_rate   = 2'b00;
  endtask

  // One clock: drive on the falling edge, advance model on the rising edge, compare 1 ns later.
  task automatic step(input bit v, input logic [7:0] d, input bit pe, input bit po,
                      input bit tk, input logic [1:0] rr);
    bit pre_idle;
    bit popped;
    popped = 1'b0;
    @(negedge clk);
    dp.data_valid = v;
    dp.data_in    = d;
    dp.par_en     = pe;
    dp.par_odd    = po;
    tick          = tk;
    rate_req      = rr;
    fd_pre        = frame_done;
    @(posedge clk);
    pre_idle = !m_active;
    m_done   = 1'b0;
    acc_now  = 1'b0;
    if (m_active && tk) begin
      if (m_q.size() > 0) begin
        m_tx   = m_q.pop_front();
        popped = 1'b1;
      end else begin
        m_active = 1'b0;
        m_done   = 1'b1;
        m_tx     = 1'b1;
      end
    end
    if (pre_idle) begin
      if (rr != 2'b11) m_rate = rr;
      if (v) begin
        model_load(d, pe, po);
        m_active = 1'b1;
        acc_now  = 1'b1;
      end
    end
    #1;
    if (popped) cap.push_back(tx);
    chk("tx",         16'(tx),            16'(m_tx));
    chk("busy",       16'(busy),          16'(m_active));
    chk("data_ready", 16'(dp.data_ready), 16'(!m_active));
    chk("frame_done", 16'(frame_done),    16'(m_done));
    chk("rate_out",   16'(rate_out),      16'(m_rate));
  endtask

  // Asynchronous reset mid-cycle; outputs must settle with no clock edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    dp.data_valid = 1'b0;
    tick          = 1'b0;
    rate_req      = 2'b00;
    rst           = 1'b0;
    #1;
    chk("rst_tx",         16'(tx),            16'd1);
    chk("rst_busy",       16'(busy),          16'd0);
    chk("rst_data_ready", 16'(dp.data_ready), 16'd1);
    chk("rst_frame_done", 16'(frame_done),    16'd0);
    chk("rst_rate_out",   16'(rate_out),      16'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] d, input bit pe, input bit po, input int period,
                           input bit tick_at_accept, input logic [1:0] rr_acc,
                           input logic [1:0] rr_busy);
    int n;
    n = 0;
    cap.delete();
    step(1'b1, d, pe, po, tick_at_accept, rr_acc);
    do begin
      n++;
      step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), (n % period) == 0, rr_busy);
    end while (!m_done && n < 2000);
    if (!m_done) begin
      n_chk++;
      $display("FAIL frame_timeout: frame 0x%0h not finished after %0d cycles", d, n);
    end
  endtask

  task automatic cmp_line(input string name, input int base, input int nbits,
                          input logic [10:0] line);
    logic [10:0] got;
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (base + i < cap.size()) got[i] = cap[base + i];
    end
    chk({name, "_bits"}, 16'(got), 16'(line));
  endtask

  initial begin
    int n;
    int acc;
    logic [7:0] cur_d;
    bit tk;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 4, 1'b0, 10, 11'b01101001010};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 4, 1'b1, 11, 11'b11000001110};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 4, 1'b0, 11, 11'b10000001110};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1, 1'b1, 10, 11'b01001111000};
    vecs[4] = '{8'h55, 1'b1, 1'b0, 2, 1'b0, 11, 11'b10010101010};

    n_pass = 0;
    n_chk  = 0;
    dp.data_valid = 1'b0;
    dp.data_in    = 8'h00;
    dp.par_en     = 1'b0;
    dp.par_odd    = 1'b0;
    model_reset();

    // Power-on reset, checked before the first clock edge.
    #1 rst = 1'b0;
    #2;
    chk("por_tx",         16'(tx),            16'd1);
    chk("por_busy",       16'(busy),          16'd0);
    chk("por_data_ready", 16'(dp.data_ready), 16'd1);
    chk("por_frame_done", 16'(frame_done),    16'd0);
    chk("por_rate_out",   16'(rate_out),      16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset mid-idle after rate_out has moved away from its reset value.
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b10);
    chk("idle_rate_set", 16'(rate_out), 16'd2);
    do_reset();

    // Directed frame table.
    for (int v = 0; v < 5; v++) begin
      run_frame(vecs[v].data, vecs[v].pe, vecs[v].po, vecs[v].period,
                vecs[v].tick_at_accept, 2'b00, 2'b00);
      chk($sformatf("vec%0d_len", v), 16'(cap.size()), 16'(vecs[v].nbits));
      cmp_line($sformatf("vec%0d", v), 0, vecs[v].nbits, vecs[v].line);
      step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    end

    // Rate request during a frame is deferred until IDLE; illegal 11 is ignored.
    run_frame(8'h81, 1'b0, 1'b0, 3, 1'b0, 2'b00, 2'b01);
    chk("rate_frozen", 16'(rate_out), 16'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01);
    chk("rate_applied", 16'(rate_out), 16'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b11);
    chk("rate_illegal_hold", 16'(rate_out), 16'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);

    // Reset after three data bits, then a clean frame.
    cap.delete();
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 2'b00);
    n = 0;
    while (cap.size() < 4 && n < 200) begin
      n++;
      step(1'b0, 8'h00, 1'b0, 1'b0, (n % 3) == 0, 2'b00);
    end
    chk("middata_tx_low", 16'(tx), 16'd0);
    do_reset();
    run_frame(8'h3C, 1'b0, 1'b0, 4, 1'b0, 2'b00, 2'b00);
    cmp_line("after_reset_3c", 0, 10, 11'b01001111000);

    // data_valid held across two bytes: second accepted in the frame_done cycle.
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    cap.delete();
    acc   = 0;
    n     = 0;
    cur_d = 8'h55;
    while ((acc < 2 || m_active) && n < 3000) begin
      tk = (n % 4) == 3;
      step(acc < 2, cur_d, 1'b0, 1'b0, tk, 2'b00);
      if (acc_now) begin
        acc++;
        if (acc == 1) cur_d = 8'hAA;
        else chk("accept_in_done_cycle", 16'(fd_pre), 16'd1);
      end
      n++;
    end
    if (n >= 3000) begin
      n_chk++;
      $display("FAIL b2b_timeout: back-to-back frames not finished");
    end
    chk("b2b_len", 16'(cap.size()), 16'd20);
    cmp_line("b2b_55", 0, 10, 11'b01010101010);
    cmp_line("b2b_aa", 10, 10, 11'b01101010100);

    // Randomized traffic with varying tick density, including back-to-back ticks.
    for (int c = 0; c < 3000; c++) begin
      case ((c / 500) % 3)
        0:       tk = $urandom_range(0, 3) == 0;
        1:       tk = 1'($urandom);
        default: tk = $urandom_range(0, 9) == 0;
      endcase
      step($urandom_range(0, 7) == 0, 8'($urandom), 1'($urandom), 1'($urandom), tk,
           2'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
